// File: rtl/axis_pkg.sv
// Shared types and keep-mask helpers for the multi-beat header inserter.
// Keep masks are passed zero-extended to KEEP_MAX bits together with the
// real byte count nb, so one set of helpers serves every bus width.
package axis_pkg;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_DATA  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam int KEEP_MAX = 64;
    typedef logic [KEEP_MAX-1:0] keep_max_t;

    // Number of set bits among the low nb bits of keep.
    function automatic int popcount_keep(input keep_max_t keep, input int nb);
        int c;
        c = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < nb && keep[i]) begin
                c++;
            end
        end
        return c;
    endfunction

    // Mask with the top cnt bits of an nb-bit keep set (first cnt bytes).
    function automatic keep_max_t keep_from_cnt(input int cnt, input int nb);
        keep_max_t m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < nb && i >= nb - cnt) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // True when the set bits form a contiguous run starting at the MSB (or none).
    function automatic logic keep_is_left_aligned(input keep_max_t keep, input int nb);
        return keep == keep_from_cnt(popcount_keep(keep, nb), nb);
    endfunction

    // True when the set bits form a contiguous run starting at the LSB (or none).
    function automatic logic keep_is_right_aligned(input keep_max_t keep, input int nb);
        keep_max_t m;
        int        cnt;
        m   = '0;
        cnt = popcount_keep(keep, nb);
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < cnt) begin
                m[i] = 1'b1;
            end
        end
        return keep == m;
    endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Combinational byte packer: appends in_cnt valid input bytes after the
// res_cnt residual bytes. emit_data is the first beat-worth of the combined
// stream, rem_data the overflow (left-aligned), total_cnt = res_cnt + in_cnt.
// Bytes past the valid count are always zero in both outputs.
module axis_byte_packer #(
    parameter int DATA_WD     = 32,
    parameter int BYTE_CNT_WD = $clog2(DATA_WD / 8)
) (
    input  logic [DATA_WD-1:0]   res_data,
    input  logic [BYTE_CNT_WD:0] res_cnt,
    input  logic [DATA_WD-1:0]   in_data,
    input  logic [BYTE_CNT_WD:0] in_cnt,
    input  logic                 in_right,
    output logic [DATA_WD-1:0]   emit_data,
    output logic [DATA_WD-1:0]   rem_data,
    output logic [BYTE_CNT_WD:0] total_cnt
);

    localparam int W  = DATA_WD / 8;
    localparam int CW = BYTE_CNT_WD + 1;

    logic [CW-1:0]        lead_cnt;
    logic [DATA_WD-1:0]   aligned;
    logic [DATA_WD-1:0]   masked;
    logic [2*DATA_WD-1:0] combined;

    // Right-aligned input (first header beat) is moved to the MSB end first.
    assign lead_cnt = CW'(W) - in_cnt;
    assign aligned  = in_right ? (in_data << {lead_cnt, 3'b000}) : in_data;

    // Zero every byte lane beyond the valid count.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign masked[DATA_WD-1-8*gi -: 8] =
                (CW'(gi) < in_cnt) ? aligned[DATA_WD-1-8*gi -: 8] : 8'h00;
        end
    endgenerate

    // Residual occupies the front; new bytes slide in right behind it.
    assign combined  = {res_data, {DATA_WD{1'b0}}}
                     | ({masked, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
    assign emit_data = combined[2*DATA_WD-1 -: DATA_WD];
    assign rem_data  = combined[DATA_WD-1:0];
    assign total_cnt = res_cnt + in_cnt;

endmodule

// File: rtl/axi_stream_insert_header_mb.sv
// Prepends a multi-beat header to an AXI-Stream payload frame and repacks
// header and payload bytes into dense MSB-first output beats, adding a flush
// beat when the final residual does not fit into the last payload output.
module axi_stream_insert_header_mb
    import axis_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic                    last_insert,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    err_keep
);

    localparam int CW = BYTE_CNT_WD + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t W_CNT = cnt_t'(DATA_BYTE_WD);

    state_t                  state_reg, state_next;
    logic [DATA_WD-1:0]      res_data_reg, res_data_next;
    cnt_t                    res_cnt_reg, res_cnt_next;
    logic                    first_hdr_reg, first_hdr_next;
    logic                    err_keep_reg, err_keep_next;
    logic                    valid_out_reg, valid_out_next;
    logic [DATA_WD-1:0]      data_out_reg, data_out_next;
    logic [DATA_BYTE_WD-1:0] keep_out_reg, keep_out_next;
    logic                    last_out_reg, last_out_next;

    logic                    can_load;
    logic                    hdr_fire, pay_fire;
    logic [DATA_WD-1:0]      sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    keep_max_t               keep_ext;
    logic                    keep_legal;
    cnt_t                    in_cnt;
    logic                    in_right;
    logic [DATA_WD-1:0]      emit_data, rem_data;
    cnt_t                    total_cnt;
    logic                    do_accum;

    assign can_load     = !valid_out_reg || ready_out;
    assign ready_insert = (state_reg == S_HDR) && can_load;
    assign ready_in     = (state_reg == S_DATA) && can_load;
    assign hdr_fire     = valid_insert && ready_insert;
    assign pay_fire     = valid_in && ready_in;

    assign valid_out = valid_out_reg;
    assign data_out  = data_out_reg;
    assign keep_out  = keep_out_reg;
    assign last_out  = last_out_reg;
    assign err_keep  = err_keep_reg;

    // Select the beat for the current state and classify its keep; an illegal
    // keep is treated as a full beat.
    always_comb begin
        sel_data   = (state_reg == S_HDR) ? data_insert : data_in;
        sel_keep   = (state_reg == S_HDR) ? keep_insert : keep_in;
        keep_ext   = keep_max_t'(sel_keep);
        keep_legal = 1'b1;
        if (state_reg == S_HDR) begin
            keep_legal = first_hdr_reg ? keep_is_right_aligned(keep_ext, DATA_BYTE_WD)
                                       : (sel_keep == '1);
        end else if (last_in) begin
            keep_legal = (sel_keep != '0) && keep_is_left_aligned(keep_ext, DATA_BYTE_WD);
        end else begin
            keep_legal = (sel_keep == '1);
        end
        in_cnt   = keep_legal ? cnt_t'(popcount_keep(keep_ext, DATA_BYTE_WD)) : W_CNT;
        in_right = (state_reg == S_HDR) && keep_legal;
    end

    axis_byte_packer #(
        .DATA_WD     (DATA_WD),
        .BYTE_CNT_WD (BYTE_CNT_WD)
    ) u_packer (
        .res_data  (res_data_reg),
        .res_cnt   (res_cnt_reg),
        .in_data   (sel_data),
        .in_cnt    (in_cnt),
        .in_right  (in_right),
        .emit_data (emit_data),
        .rem_data  (rem_data),
        .total_cnt (total_cnt)
    );

    // Next-state, residual and output-register logic.
    always_comb begin
        state_next     = state_reg;
        res_data_next  = res_data_reg;
        res_cnt_next   = res_cnt_reg;
        first_hdr_next = first_hdr_reg;
        err_keep_next  = err_keep_reg;
        valid_out_next = valid_out_reg && !ready_out;
        data_out_next  = data_out_reg;
        keep_out_next  = keep_out_reg;
        last_out_next  = last_out_reg;
        do_accum       = 1'b0;

        if (hdr_fire || pay_fire) begin
            err_keep_next = err_keep_reg | ~keep_legal;
        end

        case (state_reg)
            S_HDR: begin
                if (hdr_fire) begin
                    first_hdr_next = 1'b0;
                    do_accum       = 1'b1;
                    if (last_insert) begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pay_fire) begin
                    if (!last_in) begin
                        do_accum = 1'b1;
                    end else if (total_cnt <= W_CNT) begin
                        valid_out_next = 1'b1;
                        data_out_next  = emit_data;
                        keep_out_next  = DATA_BYTE_WD'(keep_from_cnt(int'(total_cnt), DATA_BYTE_WD));
                        last_out_next  = 1'b1;
                        res_data_next  = '0;
                        res_cnt_next   = '0;
                        first_hdr_next = 1'b1;
                        state_next     = S_HDR;
                    end else begin
                        valid_out_next = 1'b1;
                        data_out_next  = emit_data;
                        keep_out_next  = '1;
                        last_out_next  = 1'b0;
                        res_data_next  = rem_data;
                        res_cnt_next   = total_cnt - W_CNT;
                        state_next     = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (can_load) begin
                    valid_out_next = 1'b1;
                    data_out_next  = res_data_reg;
                    keep_out_next  = DATA_BYTE_WD'(keep_from_cnt(int'(res_cnt_reg), DATA_BYTE_WD));
                    last_out_next  = 1'b1;
                    res_data_next  = '0;
                    res_cnt_next   = '0;
                    first_hdr_next = 1'b1;
                    state_next     = S_HDR;
                end
            end
            default: begin
                state_next     = S_HDR;
                res_data_next  = '0;
                res_cnt_next   = '0;
                first_hdr_next = 1'b1;
            end
        endcase

        // Mid-frame beat: emit a full word once the residual spills over.
        if (do_accum) begin
            if (total_cnt >= W_CNT) begin
                valid_out_next = 1'b1;
                data_out_next  = emit_data;
                keep_out_next  = '1;
                last_out_next  = 1'b0;
                res_data_next  = rem_data;
                res_cnt_next   = total_cnt - W_CNT;
            end else begin
                res_data_next  = emit_data;
                res_cnt_next   = total_cnt;
            end
        end
    end

    // State, residual and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_HDR;
            res_data_reg  <= '0;
            res_cnt_reg   <= '0;
            first_hdr_reg <= 1'b1;
            err_keep_reg  <= 1'b0;
            valid_out_reg <= 1'b0;
            data_out_reg  <= '0;
            keep_out_reg  <= '0;
            last_out_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            res_data_reg  <= res_data_next;
            res_cnt_reg   <= res_cnt_next;
            first_hdr_reg <= first_hdr_next;
            err_keep_reg  <= err_keep_next;
            valid_out_reg <= valid_out_next;
            data_out_reg  <= data_out_next;
            keep_out_reg  <= keep_out_next;
            last_out_reg  <= last_out_next;
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// Scoreboard bench for the multi-beat header inserter (32-bit bus).
module tb_axi_stream_insert_header_mb;

    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in, last_in, ready_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          valid_insert, last_insert, ready_insert;
    logic [DW-1:0] data_insert;
    logic [BW-1:0] keep_insert;
    logic          valid_out, last_out, ready_out, err_keep;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        logic          l;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_beat = 0;

    always #5 clk = ~clk;

    axi_stream_insert_header_mb #(.DATA_WD(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_insert (valid_insert),
        .data_insert  (data_insert),
        .keep_insert  (keep_insert),
        .last_insert  (last_insert),
        .ready_insert (ready_insert),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .err_keep     (err_keep)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        sb.push_back(b);
    endtask

    task automatic send_hdr(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        int w;
        w = 0;
        @(negedge clk);
        valid_insert = 1'b1;
        data_insert  = d;
        keep_insert  = k;
        last_insert  = l;
        while (!ready_insert && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("hdr_accept_timeout", 64'(ready_insert), 64'd1);
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic send_pay(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        int w;
        w = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        while (!ready_in && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("pay_accept_timeout", 64'(ready_in), 64'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic frame1();
        expect_beat(32'hCCDD1122, 4'b1111, 1'b0);
        expect_beat(32'h33445566, 4'b1111, 1'b1);
        send_hdr(32'hAABBCCDD, 4'b0011, 1'b1);
        send_pay(32'h11223344, 4'b1111, 1'b0);
        send_pay(32'h55667788, 4'b1100, 1'b1);
    endtask

    // Output monitor: a beat is taken at the next posedge when valid&&ready here.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            n_beat++;
            $display("out beat %0d: data=%h keep=%b last=%b", n_beat, data_out, keep_out, last_out);
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(valid_out), 64'd0);
            end else begin
                exp_beat = sb.pop_front();
                chk("beat_data", 64'(data_out), 64'(exp_beat.d));
                chk("beat_keep", 64'(keep_out), 64'(exp_beat.k));
                chk("beat_last", 64'(last_out), 64'(exp_beat.l));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst          = 1'b1;
        valid_in     = 1'b0;
        data_in      = '0;
        keep_in      = '0;
        last_in      = 1'b0;
        valid_insert = 1'b0;
        data_insert  = '0;
        keep_insert  = '0;
        last_insert  = 1'b0;
        ready_out    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_keep_out", 64'(keep_out), 64'd0);
        chk("rst_last_out", 64'(last_out), 64'd0);
        chk("rst_err_keep", 64'(err_keep), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Two-byte header, payload tail fits exactly.
        frame1();
        drain();

        // Three-byte header, tail overflows into a flush beat.
        expect_beat(32'hA1A2A3B1, 4'b1111, 1'b0);
        expect_beat(32'hB2B30000, 4'b1100, 1'b1);
        send_hdr(32'h00A1A2A3, 4'b0111, 1'b1);
        send_pay(32'hB1B2B3B4, 4'b1110, 1'b1);
        @(negedge clk);
        chk("flush_ready_in", 64'(ready_in), 64'd0);
        chk("flush_ready_insert", 64'(ready_insert), 64'd0);
        drain();

        // Two-beat header.
        expect_beat(32'h99C0C1C2, 4'b1111, 1'b0);
        expect_beat(32'hC3D00000, 4'b1100, 1'b1);
        send_hdr(32'h00000099, 4'b0001, 1'b0);
        send_hdr(32'hC0C1C2C3, 4'b1111, 1'b1);
        send_pay(32'hD0D1D2D3, 4'b1000, 1'b1);
        drain();

        // Back-pressure on the first output beat of frame 1.
        @(posedge clk);
        #1 ready_out = 1'b0;
        fork
            frame1();
            begin
                w = 0;
                @(negedge clk);
                while (!valid_out && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                chk("stall_valid", 64'(valid_out), 64'd1);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("stall_data", 64'(data_out), 64'h00000000CCDD1122);
                    chk("stall_keep", 64'(keep_out), 64'hF);
                    chk("stall_last", 64'(last_out), 64'd0);
                    chk("stall_ready_in", 64'(ready_in), 64'd0);
                    chk("stall_ready_insert", 64'(ready_insert), 64'd0);
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain();

        // Zero-byte header: payload passes through one cycle later.
        expect_beat(32'h01020304, 4'b1111, 1'b0);
        expect_beat(32'h05060700, 4'b1110, 1'b1);
        send_hdr(32'hDEADBEEF, 4'b0000, 1'b1);
        send_pay(32'h01020304, 4'b1111, 1'b0);
        @(negedge clk);
        chk("zero_hdr_latency", 64'(valid_out), 64'd1);
        send_pay(32'h05060708, 4'b1110, 1'b1);
        drain();
        chk("zero_hdr_err_keep", 64'(err_keep), 64'd0);

        // Non-contiguous header keep: flagged, handled as a full beat.
        expect_beat(32'h12345678, 4'b1111, 1'b0);
        send_hdr(32'h12345678, 4'b0101, 1'b1);
        @(negedge clk);
        chk("illegal_keep_err", 64'(err_keep), 64'd1);
        expect_beat(32'h9ABCDEF0, 4'b1111, 1'b0);
        send_pay(32'h9ABCDEF0, 4'b1111, 1'b0);
        drain();
        chk("err_keep_sticky", 64'(err_keep), 64'd1);

        // Reset in the middle of the payload.
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid_out", 64'(valid_out), 64'd0);
        chk("midrst_data_out", 64'(data_out), 64'd0);
        chk("midrst_keep_out", 64'(keep_out), 64'd0);
        chk("midrst_last_out", 64'(last_out), 64'd0);
        chk("midrst_err_keep", 64'(err_keep), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        frame1();
        drain();
        chk("post_rst_err_keep", 64'(err_keep), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
